pipeline_control: RTL and testbench

- Central sequencer for the 5-stage pipeline latches (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Each cycle it produces per-latch enable and flush signals plus the PC enable.
- Inputs it acts on: instruction-memory wait (ihit), data-memory wait (dhit), load-use hazards, taken branches/jumps, and halt drain.
- Tracks completion of the outstanding data access so the MEM-stage access is never re-issued while the pipeline is held for other reasons.

---
 rtl/pipe_ctrl_pkg.sv | 20 ++
 rtl/hazard_detect.sv | 18 +
 rtl/pipeline_control.sv | 153 +++++++++++++++
 tb/tb_pipeline_control.sv | 134 +++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared types for the pipeline sequencer
package pipe_ctrl_pkg;

  localparam int REGW_DEF = 5;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    MEMWAIT = 2'd1,
    HALTED  = 2'd2
  } pctl_state_t;

  typedef logic [REGW_DEF-1:0] regbits_t;

  // Per-latch control pair: capture enable and bubble-insert on enable
  typedef struct packed {
    logic en;
    logic flush;
  } latch_ctrl_t;

endpackage

// File: rtl/hazard_detect.sv
// rtl/hazard_detect.sv - load-use hazard compare between ID/EX and IF/ID
module hazard_detect #(
  parameter int REGW = pipe_ctrl_pkg::REGW_DEF
) (
  input  logic            idex_memread_i,
  input  logic [REGW-1:0] idex_rt_i,
  input  logic [REGW-1:0] ifid_rs_i,
  input  logic [REGW-1:0] ifid_rt_i,
  output logic            loaduse_o
);

  // Register 0 is hardwired, so a load targeting it never creates a hazard
  always_comb begin
    loaduse_o = idex_memread_i && (idex_rt_i != '0) &&
                ((idex_rt_i == ifid_rs_i) || (idex_rt_i == ifid_rt_i));
  end

endmodule

// File: rtl/pipeline_control.sv
// rtl/pipeline_control.sv - pipeline latch sequencer (PIPE_PERF_EN adds perf counters)
module pipeline_control
  import pipe_ctrl_pkg::*;
#(
  parameter int REGW = REGW_DEF
`ifdef PIPE_PERF_EN
  , parameter int CNT_W = 32
`endif
) (
  input  logic            CLK,
  input  logic            nRST,
  input  logic            ihit,
  input  logic            dhit,
  input  logic            mem_ren,
  input  logic            mem_wen,
  input  logic            exmem_halt,
  input  logic            memwb_halt,
  input  logic            idex_memread,
  input  logic [REGW-1:0] idex_rt,
  input  logic [REGW-1:0] ifid_rs,
  input  logic [REGW-1:0] ifid_rt,
  input  logic            branch_taken,
  input  logic            jump,
  output logic            pc_en,
  output logic            ifid_en,
  output logic            idex_en,
  output logic            exmem_en,
  output logic            memwb_en,
  output logic            ifid_flush,
  output logic            idex_flush,
  output logic            exmem_flush,
  output logic            dmem_req,
  output logic            halt
`ifdef PIPE_PERF_EN
  ,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] lu_cnt
`endif
);

  pctl_state_t state_q, state_d;
  logic        dmem_done_q, dmem_done_d;
  logic        loaduse, dmem_op, dmem_ok, fetch_ok, adv, lu_stall, halted;
  latch_ctrl_t ifid_c, idex_c, exmem_c;

  hazard_detect #(.REGW(REGW)) u_hazard (
    .idex_memread_i (idex_memread),
    .idex_rt_i      (idex_rt),
    .ifid_rs_i      (ifid_rs),
    .ifid_rt_i      (ifid_rt),
    .loaduse_o      (loaduse)
  );

  // Latch enables/flushes by priority; everything is forced low during reset
  always_comb begin
    halted   = (state_q == HALTED);
    dmem_op  = mem_ren | mem_wen;
    dmem_ok  = !dmem_op || dhit || dmem_done_q;
    fetch_ok = ihit || exmem_halt;
    adv      = dmem_ok && fetch_ok;
    pc_en    = 1'b0;
    memwb_en = 1'b0;
    ifid_c   = '0;
    idex_c   = '0;
    exmem_c  = '0;
    lu_stall = 1'b0;
    if (nRST && !halted && adv) begin
      if (exmem_halt) begin
        // Let halt drain toward WB but stop fetching anything behind it
        exmem_c  = '{en: 1'b1, flush: 1'b1};
        memwb_en = 1'b1;
      end else begin
        pc_en      = 1'b1;
        ifid_c.en  = 1'b1;
        idex_c.en  = 1'b1;
        exmem_c.en = 1'b1;
        memwb_en   = 1'b1;
        if (branch_taken) begin
          ifid_c.flush = 1'b1;
          idex_c.flush = 1'b1;
        end else if (loaduse) begin
          pc_en        = 1'b0;
          ifid_c.en    = 1'b0;
          idex_c.flush = 1'b1;
          lu_stall     = 1'b1;
        end else if (jump) begin
          ifid_c.flush = 1'b1;
        end
      end
    end
    ifid_en     = ifid_c.en;
    idex_en     = idex_c.en;
    exmem_en    = exmem_c.en;
    ifid_flush  = ifid_c.flush;
    idex_flush  = idex_c.flush;
    exmem_flush = exmem_c.flush;
    dmem_req    = nRST && dmem_op && !dmem_done_q && !halted;
    halt        = halted;
  end

  // Next state and data-access completion memory
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (dmem_req && !dhit) state_d = MEMWAIT;
      MEMWAIT: if (dhit) state_d = RUN;
      default: state_d = HALTED;
    endcase
    if (memwb_halt) state_d = HALTED;
    // A finished access is remembered until the latch actually moves on
    if (exmem_en)  dmem_done_d = 1'b0;
    else if (dhit) dmem_done_d = 1'b1;
    else           dmem_done_d = dmem_done_q;
  end

  // State and dmem_done registers
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q     <= RUN;
      dmem_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      dmem_done_q <= dmem_done_d;
    end
  end

`ifdef PIPE_PERF_EN
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q, lu_cnt_q;

  // Saturating event counters, frozen once halted
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
      lu_cnt_q    <= '0;
    end else if (!halted) begin
      if (!adv && stall_cnt_q != '1) stall_cnt_q <= stall_cnt_q + 1'b1;
      if ((ifid_flush || idex_flush || exmem_flush) && flush_cnt_q != '1)
        flush_cnt_q <= flush_cnt_q + 1'b1;
      if (lu_stall && lu_cnt_q != '1) lu_cnt_q <= lu_cnt_q + 1'b1;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
  assign lu_cnt    = lu_cnt_q;
`else
  logic unused_lu;
  assign unused_lu = lu_stall;
`endif

endmodule

// File: tb/tb_pipeline_control.sv
// tb/tb_pipeline_control.sv - directed self-checking bench for pipeline_control
module tb_pipeline_control;
  import pipe_ctrl_pkg::*;

  logic CLK = 1'b0;
  logic nRST, ihit, dhit, mem_ren, mem_wen, exmem_halt, memwb_halt;
  logic idex_memread, branch_taken, jump;
  regbits_t idex_rt, ifid_rs, ifid_rt;
  logic pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic ifid_flush, idex_flush, exmem_flush, dmem_req, halt;
`ifdef PIPE_PERF_EN
  logic [31:0] stall_cnt, flush_cnt, lu_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  pipeline_control dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit),
    .mem_ren(mem_ren), .mem_wen(mem_wen),
    .exmem_halt(exmem_halt), .memwb_halt(memwb_halt),
    .idex_memread(idex_memread), .idex_rt(idex_rt),
    .ifid_rs(ifid_rs), .ifid_rt(ifid_rt),
    .branch_taken(branch_taken), .jump(jump),
    .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en),
    .exmem_en(exmem_en), .memwb_en(memwb_en),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .exmem_flush(exmem_flush), .dmem_req(dmem_req), .halt(halt)
`ifdef PIPE_PERF_EN
    , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .lu_cnt(lu_cnt)
`endif
  );

  // Output bundle order: pc ifid idex exmem memwb | fl_ifid fl_idex fl_exmem | req halt
  function automatic logic [9:0] outs();
    return {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
            ifid_flush, idex_flush, exmem_flush, dmem_req, halt};
  endfunction

  task automatic check(input string tag, input logic [9:0] obs, input logic [9:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Check outputs mid-cycle, then move to just after the next rising edge
  task automatic cyc(input string tag, input logic [9:0] exp);
    @(negedge CLK);
    check(tag, outs(), exp);
    @(posedge CLK);
    #1;
  endtask

  initial begin
    nRST = 1'b0; ihit = 1'b1; dhit = 1'b0; mem_ren = 1'b0; mem_wen = 1'b0;
    exmem_halt = 1'b0; memwb_halt = 1'b0; idex_memread = 1'b0;
    branch_taken = 1'b0; jump = 1'b0;
    idex_rt = '0; ifid_rs = '0; ifid_rt = '0;

    #2 check("reset_outs", outs(), 10'b0000000000);
    @(posedge CLK); #1 nRST = 1'b1;

    cyc("run_free", 10'b1111100000);
    #2 nRST = 1'b0;
    #1 check("async_rst", outs(), 10'b0000000000);
    #1 nRST = 1'b1;
    @(posedge CLK); #1;

    // Load waits three cycles on dhit
    mem_ren = 1'b1;
    for (int i = 0; i < 3; i++) cyc("ld_wait", 10'b0000000010);
    dhit = 1'b1;
    cyc("ld_done", 10'b1111100010);
    mem_ren = 1'b0; dhit = 1'b0;
    cyc("after_ld", 10'b1111100000);

    // Store completes while fetch is stalled; no re-request afterwards
    mem_wen = 1'b1; dhit = 1'b1; ihit = 1'b0;
    cyc("st_ihold", 10'b0000000010);
    dhit = 1'b0; ihit = 1'b1;
    cyc("st_done_adv", 10'b1111100000);
    cyc("st_done_clr", 10'b0000000010);
    dhit = 1'b1;
    cyc("st2_done", 10'b1111100010);
    mem_wen = 1'b0; dhit = 1'b0;

    // Load-use hazards
    idex_memread = 1'b1; idex_rt = 5'd5; ifid_rs = 5'd5;
    cyc("lu_rs", 10'b0011101000);
    idex_rt = 5'd0; ifid_rs = 5'd0;
    cyc("lu_r0", 10'b1111100000);
    idex_rt = 5'd7; ifid_rt = 5'd7; ifid_rs = 5'd3;
    cyc("lu_rt", 10'b0011101000);
    idex_memread = 1'b0;
    cyc("lu_noread", 10'b1111100000);

    // Control-flow priority
    idex_memread = 1'b1; branch_taken = 1'b1;
    cyc("br_over_lu", 10'b1111111000);
    branch_taken = 1'b0; jump = 1'b1;
    cyc("lu_over_jmp", 10'b0011101000);
    idex_memread = 1'b0;
    cyc("jump", 10'b1111110000);
    jump = 1'b0; idex_rt = '0; ifid_rt = '0; ifid_rs = '0;

    // Halt drain with a pending data access when memwb_halt arrives
    exmem_halt = 1'b1; ihit = 1'b0;
    cyc("exmem_halt", 10'b0001100100);
    exmem_halt = 1'b0; ihit = 1'b1; memwb_halt = 1'b1; mem_ren = 1'b1;
    cyc("memwb_halt", 10'b0000000010);
    memwb_halt = 1'b0;
    for (int i = 0; i < 12; i++) begin
      ihit = i[0]; dhit = i[1]; branch_taken = i[2]; jump = i[0];
      mem_wen = i[1]; idex_memread = 1'b1; idex_rt = 5'd4; ifid_rs = 5'd4;
      cyc("halted", 10'b0000000001);
    end

    // Reset leaves HALTED and returns to running
    mem_ren = 1'b0; mem_wen = 1'b0; dhit = 1'b0; ihit = 1'b1;
    branch_taken = 1'b0; jump = 1'b0; idex_memread = 1'b0;
    nRST = 1'b0;
    #1 check("rst_halted", outs(), 10'b0000000000);
    @(posedge CLK); #1 nRST = 1'b1;
    cyc("post_halt_run", 10'b1111100000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
